cnt_bank_sched: RTL and testbench

//   Scheduler for a bank of NUM_CNT event counters that share one WIDTH-bit incrementer.

---
 rtl/cnt_bank_sched.sv | 106 ++++++++++
 tb/tb_cnt_bank_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cnt_bank_sched.sv
// Round-robin scheduler for a bank of event counters sharing one incrementer.
// Requests are latched as pending, one counter is advanced per cycle, clears win over everything.
module cnt_bank_sched #(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned WIDTH   = 8,
  parameter bit          SAT     = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic [NUM_CNT-1:0]         req,
  input  logic [NUM_CNT-1:0]         clr,
  output logic [NUM_CNT-1:0]         pend,
  output logic [NUM_CNT-1:0]         gnt,
  output logic                       gnt_vld,
  output logic [NUM_CNT-1:0]         coal,
  output logic [NUM_CNT*WIDTH-1:0]   cnt_flat
);

  localparam int unsigned PTR_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_PAUSE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [WIDTH-1:0]   cnt [NUM_CNT];

  logic [PTR_W-1:0]   idx;
  logic [PTR_W-1:0]   win_idx;
  logic               win_vld;
  logic               do_gnt;
  logic [NUM_CNT-1:0] gnt_nx;
  logic [NUM_CNT-1:0] pend_nx;
  logic [NUM_CNT-1:0] coal_nx;

  // Winner search from rr_ptr with wrap-around, then grant/pending/coalesce next values
  always_comb begin
    idx     = '0;
    win_idx = '0;
    win_vld = 1'b0;
    for (int j = 0; j < int'(NUM_CNT); j++) begin
      idx = PTR_W'((int'(rr_ptr) + j) % int'(NUM_CNT));
      if (!win_vld && pend[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
    do_gnt = (state == S_SERVE) && en && win_vld;
    gnt_nx = '0;
    for (int i = 0; i < int'(NUM_CNT); i++) begin
      gnt_nx[i] = do_gnt && (win_idx == PTR_W'(i));
    end
    pend_nx = ~clr & (req | (pend & ~gnt_nx));
    coal_nx = ~clr & (coal | (req & pend & ~gnt_nx));
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      pend    <= '0;
      coal    <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      pend    <= pend_nx;
      coal    <= coal_nx;
      gnt     <= gnt_nx;
      gnt_vld <= do_gnt;
      // Pointer moves past the winner even when a same-edge clear discards the increment
      if (do_gnt) begin
        rr_ptr <= (win_idx == PTR_W'(NUM_CNT - 1)) ? '0 : win_idx + PTR_W'(1);
      end
      for (int i = 0; i < int'(NUM_CNT); i++) begin
        if (clr[i]) begin
          cnt[i] <= '0;
        end else if (gnt_nx[i]) begin
          if (!(SAT && (cnt[i] == {WIDTH{1'b1}}))) begin
            cnt[i] <= cnt[i] + WIDTH'(1);
          end
        end
      end
      case (state)
        S_IDLE: begin
          if (en && (pend_nx != '0)) state <= S_SERVE;
        end
        S_SERVE: begin
          if (!en)                  state <= S_PAUSE;
          else if (pend_nx == '0)   state <= S_IDLE;
        end
        S_PAUSE: begin
          if (en) state <= (pend != '0) ? S_SERVE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < int'(NUM_CNT); g++) begin : g_flat
    assign cnt_flat[g*WIDTH +: WIDTH] = cnt[g];
  end

endmodule

// File: tb/tb_cnt_bank_sched.sv
// Bench for cnt_bank_sched: wrapping and saturating instances share stimulus and are
// checked every cycle against an integer-level model, plus directed literal checks.
module tb_cnt_bank_sched;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         en  = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] clr = '0;

  logic [N-1:0]   pend0, gnt0, coal0, pend1, gnt1, coal1;
  logic           gnt_vld0, gnt_vld1;
  logic [N*W-1:0] cnt_flat0, cnt_flat1;

  int tests = 0;
  int fails = 0;

  cnt_bank_sched #(.NUM_CNT(N), .WIDTH(W), .SAT(1'b0)) u_wrap (
    .CLK(CLK), .RST(RST), .en(en), .req(req), .clr(clr),
    .pend(pend0), .gnt(gnt0), .gnt_vld(gnt_vld0), .coal(coal0), .cnt_flat(cnt_flat0)
  );

  cnt_bank_sched #(.NUM_CNT(N), .WIDTH(W), .SAT(1'b1)) u_sat (
    .CLK(CLK), .RST(RST), .en(en), .req(req), .clr(clr),
    .pend(pend1), .gnt(gnt1), .gnt_vld(gnt_vld1), .coal(coal1), .cnt_flat(cnt_flat1)
  );

  initial forever #5 CLK = ~CLK;

  // Model state per instance: 0 = wrapping, 1 = saturating; mode 0 idle, 1 serve, 2 pause
  logic [N-1:0] m_pend [2];
  logic [N-1:0] m_coal [2];
  logic [N-1:0] m_gnt  [2];
  logic         m_gv   [2];
  int           m_ptr  [2];
  int           m_mode [2];
  int           m_cnt  [2][N];
  bit           m_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int w;
    int c;
    logic [N-1:0] np;
    logic [N-1:0] nc;
    if (!RST) begin
      m_pend[k] = '0; m_coal[k] = '0; m_gnt[k] = '0; m_gv[k] = 1'b0;
      m_ptr[k]  = 0;  m_mode[k] = 0;
      for (int i = 0; i < N; i++) m_cnt[k][i] = 0;
      m_valid = 1'b1;
      return;
    end
    w = -1;
    if (m_mode[k] == 1 && en) begin
      for (int j = 0; j < N; j++) begin
        if (w < 0 && m_pend[k][(m_ptr[k] + j) % N]) w = (m_ptr[k] + j) % N;
      end
    end
    np = '0;
    nc = '0;
    for (int i = 0; i < N; i++) begin
      if (clr[i]) begin
        m_cnt[k][i] = 0;
      end else begin
        nc[i] = m_coal[k][i] | (req[i] & m_pend[k][i] & (i != w));
        np[i] = req[i] | (m_pend[k][i] & (i != w));
        if (i == w) begin
          c = m_cnt[k][i] + 1;
          if (c > MAXV) c = (k == 1) ? MAXV : 0;
          m_cnt[k][i] = c;
        end
      end
    end
    m_gnt[k] = (w >= 0) ? N'(1 << w) : '0;
    m_gv[k]  = (w >= 0);
    if (w >= 0) m_ptr[k] = (w + 1) % N;
    case (m_mode[k])
      0: if (en && np != '0) m_mode[k] = 1;
      1: if (!en) m_mode[k] = 2; else if (np == '0) m_mode[k] = 0;
      default: if (en) m_mode[k] = (m_pend[k] != '0) ? 1 : 0;
    endcase
    m_pend[k] = np;
    m_coal[k] = nc;
  endtask

  // Advance the model on every edge and compare both instances just after it
  always @(posedge CLK) begin
    logic [N*W-1:0] ef;
    model_step(0);
    model_step(1);
    #1;
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        ef = '0;
        for (int i = 0; i < N; i++) ef[i*W +: W] = W'(m_cnt[k][i]);
        chk($sformatf("pend[%0d]", k),    32'(k ? pend1 : pend0), 32'(m_pend[k]));
        chk($sformatf("gnt[%0d]", k),     32'(k ? gnt1 : gnt0),   32'(m_gnt[k]));
        chk($sformatf("gnt_vld[%0d]", k), 32'(k ? gnt_vld1 : gnt_vld0), 32'(m_gv[k]));
        chk($sformatf("coal[%0d]", k),    32'(k ? coal1 : coal0), 32'(m_coal[k]));
        chk($sformatf("cnt_flat[%0d]", k), 32'(k ? cnt_flat1 : cnt_flat0), 32'(ef));
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [N-1:0] q, input logic [N-1:0] c);
    @(negedge CLK);
    RST = r; en = e; req = q; clr = c;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    logic [N-1:0] eg;
    // Reset held with all requests asserted
    step(1'b0, 1'b1, 4'b1111, 4'b0000);
    step(1'b0, 1'b1, 4'b1111, 4'b0000);
    chk("rst_pend", 32'(pend0), 32'h0);
    chk("rst_gnt_vld", 32'(gnt_vld0), 32'h0);
    chk("rst_cnt", 32'(cnt_flat0), 32'h0);

    // Single request: pending after one edge, granted after the next
    step(1'b1, 1'b1, 4'b0100, 4'b0000);
    chk("single_pend", 32'(pend0), 32'h4);
    chk("single_nognt", 32'(gnt_vld0), 32'h0);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("single_gnt", 32'(gnt0), 32'h4);
    chk("single_cnt2", 32'(cnt_flat0[23:16]), 32'h1);

    // All four at once from a fresh pointer: grants 0,1,2,3 in order
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 4'b1111, 4'b0000);
    for (int g = 0; g < N; g++) begin
      step(1'b1, 1'b1, 4'b0000, 4'b0000);
      eg = 4'b0001 << g;
      chk($sformatf("rr_gnt%0d", g), 32'(gnt0), 32'(eg));
    end
    chk("rr_cnts", 32'(cnt_flat0), 32'h01010101);

    // Drive counter 0 to max, then one more event: wrap vs saturate
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    repeat (255) step(1'b1, 1'b1, 4'b0001, 4'b0000);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("pre_max_wrap", 32'(cnt_flat0), 32'hFF);
    chk("pre_max_sat", 32'(cnt_flat1), 32'hFF);
    step(1'b1, 1'b1, 4'b0001, 4'b0000);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("wrap_cnt0", 32'(cnt_flat0[7:0]), 32'h0);
    chk("sat_cnt0", 32'(cnt_flat1[7:0]), 32'hFF);
    chk("sat_gnt_vld", 32'(gnt_vld1), 32'h1);

    // Two events while disabled merge into one
    step(1'b1, 1'b0, 4'b0010, 4'b0000);
    step(1'b1, 1'b0, 4'b0010, 4'b0000);
    chk("merge_coal", 32'(coal0), 32'h2);
    chk("merge_pend", 32'(pend0), 32'h2);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    chk("merge_gnt", 32'(gnt0), 32'h2);
    chk("merge_cnt1", 32'(cnt_flat0[15:8]), 32'h1);

    // Clear on the same edge as a grant to that counter
    step(1'b1, 1'b1, 4'b1000, 4'b0000);
    step(1'b1, 1'b1, 4'b1000, 4'b0000);
    chk("pre_clr_cnt3", 32'(cnt_flat0[31:24]), 32'h1);
    step(1'b1, 1'b1, 4'b0000, 4'b1000);
    chk("clr_gnt", 32'(gnt0), 32'h8);
    chk("clr_cnt3", 32'(cnt_flat0[31:24]), 32'h0);
    chk("clr_pend3", 32'(pend0[3]), 32'h0);

    // Reset in the middle of serving
    step(1'b1, 1'b1, 4'b1010, 4'b0000);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    chk("mid_rst_pend", 32'(pend0), 32'h0);
    chk("mid_rst_gnt", 32'(gnt0), 32'h0);
    chk("mid_rst_vld", 32'(gnt_vld0), 32'h0);
    chk("mid_rst_coal", 32'(coal0), 32'h0);
    chk("mid_rst_cnt", 32'(cnt_flat0), 32'h0);
    chk("mid_rst_cnt_sat", 32'(cnt_flat1), 32'h0);

    // Randomised traffic checked by the per-cycle compare process
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 9) < 8,
           N'($urandom),
           ($urandom_range(0, 15) == 0) ? N'($urandom) : '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
